// File: rtl/switch_debounce.sv
// Switch conditioner: two-flop synchroniser, programmable debounce, edge events,
// press counter and level interrupt behind a zero-wait-state APB slave.
module switch_debounce #(
    parameter int unsigned DB_WIDTH   = 20,
    parameter int unsigned DB_DEFAULT = 500000,
    parameter int unsigned CNT_WIDTH  = 16
) (
    input  logic        PCLK,
    input  logic        PRESETN,
    input  logic        PSEL,
    input  logic        PENABLE,
    input  logic        PWRITE,
    input  logic [7:0]  PADDR,
    input  logic [31:0] PWDATA,
    output logic [31:0] PRDATA,
    output logic        PREADY,
    output logic        PSLVERR,
    input  logic        SW_RAW,
    output logic        SWITCH,
    output logic        SWINT
);

    typedef enum logic [0:0] {StStable, StCounting} db_state_e;

    logic                 sync1_q, sync2_q;
    logic                 en_q, rise_ie_q, fall_ie_q;
    logic [DB_WIDTH-1:0]  db_q;
    db_state_e            state_q, state_d;
    logic [DB_WIDTH-1:0]  stab_cnt_q, stab_cnt_d;
    logic                 switch_q, switch_d;
    logic                 rise_pend_q, rise_pend_d;
    logic                 fall_pend_q, fall_pend_d;
    logic [CNT_WIDTH-1:0] presses_q, presses_d;
    logic                 swint_q;

    logic wr_en, rd_en, wr_ctrl, wr_db, wr_status, wr_presses;
    logic toggle, rise_evt, fall_evt;
    logic unused_wdata;

    assign wr_en      = PSEL & PENABLE & PWRITE;
    assign rd_en      = PSEL & ~PWRITE;
    assign wr_ctrl    = wr_en && (PADDR == 8'h00);
    assign wr_db      = wr_en && (PADDR == 8'h04);
    assign wr_status  = wr_en && (PADDR == 8'h08);
    assign wr_presses = wr_en && (PADDR == 8'h0C);

    assign PREADY       = 1'b1;
    assign PSLVERR      = 1'b0;
    assign SWITCH       = switch_q;
    assign SWINT        = swint_q;
    assign unused_wdata = ^PWDATA;

    always_ff @(posedge PCLK or negedge PRESETN) begin
        if (!PRESETN) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= SW_RAW;
            sync2_q <= sync1_q;
        end
    end

    // A threshold write restarts qualification so a count never spans two thresholds.
    always_comb begin
        state_d    = state_q;
        stab_cnt_d = stab_cnt_q;
        toggle     = 1'b0;
        if (!en_q || wr_db) begin
            state_d    = StStable;
            stab_cnt_d = '0;
        end else begin
            case (state_q)
                StStable: begin
                    if (sync2_q != switch_q) begin
                        state_d    = StCounting;
                        stab_cnt_d = '0;
                    end
                end
                StCounting: begin
                    if (sync2_q == switch_q) begin
                        state_d    = StStable;
                        stab_cnt_d = '0;
                    end else if (stab_cnt_q == db_q) begin
                        toggle     = 1'b1;
                        state_d    = StStable;
                        stab_cnt_d = '0;
                    end else begin
                        stab_cnt_d = stab_cnt_q + DB_WIDTH'(1);
                    end
                end
                default: begin
                    state_d    = StStable;
                    stab_cnt_d = '0;
                end
            endcase
        end
    end

    // Hardware set beats a same-cycle W1C; a clear on an increment cycle keeps that press.
    always_comb begin
        switch_d    = switch_q ^ toggle;
        rise_evt    = toggle & ~switch_q;
        fall_evt    = toggle & switch_q;
        rise_pend_d = rise_evt | (rise_pend_q & ~(wr_status & PWDATA[1]));
        fall_pend_d = fall_evt | (fall_pend_q & ~(wr_status & PWDATA[2]));
        presses_d   = presses_q;
        if (wr_presses) begin
            presses_d = rise_evt ? CNT_WIDTH'(1) : '0;
        end else if (rise_evt) begin
            presses_d = presses_q + CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge PCLK or negedge PRESETN) begin
        if (!PRESETN) begin
            state_q     <= StStable;
            stab_cnt_q  <= '0;
            switch_q    <= 1'b0;
            rise_pend_q <= 1'b0;
            fall_pend_q <= 1'b0;
            presses_q   <= '0;
            swint_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            stab_cnt_q  <= stab_cnt_d;
            switch_q    <= switch_d;
            rise_pend_q <= rise_pend_d;
            fall_pend_q <= fall_pend_d;
            presses_q   <= presses_d;
            swint_q     <= (rise_pend_q & rise_ie_q) | (fall_pend_q & fall_ie_q);
        end
    end

    always_ff @(posedge PCLK or negedge PRESETN) begin
        if (!PRESETN) begin
            en_q      <= 1'b0;
            rise_ie_q <= 1'b0;
            fall_ie_q <= 1'b0;
            db_q      <= DB_WIDTH'(DB_DEFAULT);
        end else begin
            if (wr_ctrl) begin
                en_q      <= PWDATA[0];
                rise_ie_q <= PWDATA[1];
                fall_ie_q <= PWDATA[2];
            end
            if (wr_db) begin
                db_q <= PWDATA[DB_WIDTH-1:0];
            end
        end
    end

    always_comb begin
        PRDATA = '0;
        if (rd_en) begin
            case (PADDR)
                8'h00:   PRDATA[2:0] = {fall_ie_q, rise_ie_q, en_q};
                8'h04:   PRDATA[DB_WIDTH-1:0] = db_q;
                8'h08:   PRDATA[2:0] = {fall_pend_q, rise_pend_q, switch_q};
                8'h0C:   PRDATA[CNT_WIDTH-1:0] = presses_q;
                default: PRDATA = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_switch_debounce.sv
// Randomised bench for switch_debounce: a run-length reference model predicts
// SWITCH edges and register contents; a negedge monitor checks them from queues.
module tb_switch_debounce;

    // Narrow press counter so the wrap case needs only 256 presses.
    localparam int unsigned CNT_W  = 8;
    localparam int unsigned DB_DEF = 500000;

    logic        PCLK = 1'b0;
    logic        PRESETN = 1'b1;
    logic        PSEL = 1'b0, PENABLE = 1'b0, PWRITE = 1'b0;
    logic [7:0]  PADDR = 8'h00;
    logic [31:0] PWDATA = 32'h0;
    logic [31:0] PRDATA;
    logic        PREADY, PSLVERR;
    logic        SW_RAW = 1'b0;
    logic        SWITCH, SWINT;

    switch_debounce #(
        .DB_WIDTH  (20),
        .DB_DEFAULT(DB_DEF),
        .CNT_WIDTH (CNT_W)
    ) dut (
        .PCLK   (PCLK),
        .PRESETN(PRESETN),
        .PSEL   (PSEL),
        .PENABLE(PENABLE),
        .PWRITE (PWRITE),
        .PADDR  (PADDR),
        .PWDATA (PWDATA),
        .PRDATA (PRDATA),
        .PREADY (PREADY),
        .PSLVERR(PSLVERR),
        .SW_RAW (SW_RAW),
        .SWITCH (SWITCH),
        .SWINT  (SWINT)
    );

    always #5 PCLK = ~PCLK;

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    int unsigned cyc = 0;
    bit          h1, h2, md, mw, mtog, mrise, mfall;
    bit          m_sw, m_en, m_rie, m_fie, m_rp, m_fp, m_swint;
    int unsigned m_n, m_run, m_presses;
    int unsigned ev_cyc_q[$];
    bit          ev_lvl_q[$];
    logic [31:0] rd_q[$];
    logic [7:0]  rd_addr_q[$];

    // SWITCH adopts the synchronised raw level once it has disagreed for N+2 straight cycles.
    always @(posedge PCLK or negedge PRESETN) begin
        if (!PRESETN) begin
            if (m_sw) begin
                ev_cyc_q.push_back(cyc);
                ev_lvl_q.push_back(1'b0);
            end
            h1 = 0; h2 = 0; m_sw = 0; m_en = 0; m_rie = 0; m_fie = 0;
            m_rp = 0; m_fp = 0; m_swint = 0; m_n = DB_DEF; m_run = 0; m_presses = 0;
        end else begin
            cyc++;
            mw = PSEL && PENABLE && PWRITE;
            md = h2;
            h2 = h1;
            h1 = SW_RAW;
            mtog = 0;
            if (!m_en || (mw && PADDR == 8'h04)) begin
                m_run = 0;
            end else if (md != m_sw) begin
                m_run++;
                if (m_run == m_n + 2) begin
                    mtog  = 1;
                    m_run = 0;
                end
            end else begin
                m_run = 0;
            end
            mrise   = mtog && !m_sw;
            mfall   = mtog && m_sw;
            m_swint = (m_rp && m_rie) || (m_fp && m_fie);
            if (mw && PADDR == 8'h08) begin
                if (PWDATA[1]) m_rp = 0;
                if (PWDATA[2]) m_fp = 0;
            end
            if (mrise) m_rp = 1;
            if (mfall) m_fp = 1;
            if (mw && PADDR == 8'h0C) m_presses = mrise ? 1 : 0;
            else if (mrise) m_presses = (m_presses + 1) % (1 << CNT_W);
            if (mw && PADDR == 8'h00) {m_fie, m_rie, m_en} = PWDATA[2:0];
            if (mw && PADDR == 8'h04) m_n = PWDATA[19:0];
            if (mtog) begin
                m_sw = !m_sw;
                ev_cyc_q.push_back(cyc);
                ev_lvl_q.push_back(m_sw);
            end
        end
    end

    function automatic logic [31:0] model_reg(input logic [7:0] a);
        case (a)
            8'h00:   return {29'd0, m_fie, m_rie, m_en};
            8'h04:   return m_n;
            8'h08:   return {29'd0, m_fp, m_rp, m_sw};
            8'h0C:   return m_presses;
            default: return 32'd0;
        endcase
    endfunction

    // ---------------- monitor ----------------
    logic last_sw = 1'b0;

    always @(negedge PCLK) begin
        check("swint", {31'd0, SWINT}, {31'd0, m_swint});
        if (!(PSEL && !PWRITE)) check("prdata_idle", PRDATA, 32'd0);
        if (PSEL && PENABLE && !PWRITE) begin
            if (rd_q.size() == 0) begin
                check("unexpected_read", PRDATA, 32'hDEAD_BEEF);
            end else begin
                check($sformatf("read_0x%02h", rd_addr_q.pop_front()), PRDATA, rd_q.pop_front());
            end
        end
        if (SWITCH !== last_sw) begin
            if (ev_cyc_q.size() == 0) begin
                check("unexpected_switch_edge", {31'd0, SWITCH}, {31'd0, last_sw});
            end else begin
                check("switch_edge_cycle", cyc, ev_cyc_q.pop_front());
                check("switch_edge_level", {31'd0, SWITCH}, {31'd0, ev_lvl_q.pop_front()});
            end
            last_sw = SWITCH;
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge PCLK);
        #1;
    endtask

    task automatic hold(input bit v, input int unsigned n);
        SW_RAW = v;
        repeat (n) tick();
    endtask

    task automatic apb_write(input logic [7:0] a, input logic [31:0] d);
        PSEL = 1; PWRITE = 1; PENABLE = 0; PADDR = a; PWDATA = d;
        tick();
        PENABLE = 1;
        tick();
        PSEL = 0; PENABLE = 0; PWRITE = 0;
    endtask

    task automatic apb_read(input logic [7:0] a);
        PSEL = 1; PWRITE = 0; PENABLE = 0; PADDR = a;
        tick();
        PENABLE = 1;
        rd_q.push_back(model_reg(a));
        rd_addr_q.push_back(a);
        tick();
        PSEL = 0; PENABLE = 0;
    endtask

    task automatic read_all();
        apb_read(8'h00);
        apb_read(8'h04);
        apb_read(8'h08);
        apb_read(8'h0C);
    endtask

    initial begin
        #2 PRESETN = 0;
        repeat (3) @(posedge PCLK);
        #1 PRESETN = 1;
        tick();
        check("reset_switch", {31'd0, SWITCH}, 32'd0);
        check("reset_swint", {31'd0, SWINT}, 32'd0);
        check("pready", {31'd0, PREADY}, 32'd1);
        check("pslverr", {31'd0, PSLVERR}, 32'd0);
        read_all();
        apb_read(8'h10);

        // Clean rise with N = 3: SWITCH must toggle on edge 7 after SW_RAW moves.
        apb_write(8'h04, 32'd3);
        apb_write(8'h00, 32'h7);
        hold(0, 4);
        SW_RAW = 1;
        repeat (6) tick();
        check("rise_before_edge7", {31'd0, SWITCH}, 32'd0);
        tick();
        check("rise_at_edge7", {31'd0, SWITCH}, 32'd1);
        tick();
        check("swint_after_rise", {31'd0, SWINT}, 32'd1);
        apb_read(8'h08);
        apb_read(8'h0C);

        // W1C of RISE_PEND, then a fall, then W1C coinciding with a new rise.
        apb_write(8'h08, 32'h2);
        apb_read(8'h08);
        hold(0, 10);
        apb_write(8'h08, 32'h4);
        SW_RAW = 1;
        repeat (5) tick();
        apb_write(8'h08, 32'h2);
        apb_read(8'h08);

        // Glitches shorter than N+2 must never reach SWITCH.
        hold(0, 10);
        apb_write(8'h08, 32'h6);
        for (int i = 0; i < 10; i++) begin
            hold(1, $urandom_range(1, 4));
            hold(0, $urandom_range(2, 6));
        end
        hold(0, 8);
        check("glitch_switch", {31'd0, SWITCH}, {31'd0, m_sw});
        read_all();

        // Random bounce sequences.
        for (int i = 0; i < 40; i++) hold($urandom_range(0, 1), $urandom_range(1, 9));
        hold(1, 12);
        read_all();

        // Disabled: SWITCH frozen; re-enable and follow.
        apb_write(8'h00, 32'h6);
        for (int i = 0; i < 8; i++) hold(~SW_RAW, $urandom_range(3, 12));
        hold(~m_sw, 10);
        apb_read(8'h08);
        apb_write(8'h00, 32'h7);
        hold(SW_RAW, 10);
        read_all();

        // N = 0 press counter wrap.
        apb_write(8'h04, 32'd0);
        apb_write(8'h00, 32'h1);
        hold(0, 6);
        apb_write(8'h08, 32'h6);
        apb_write(8'h0C, 32'h0);
        for (int i = 0; i < (1 << CNT_W); i++) begin
            hold(1, $urandom_range(2, 5));
            hold(0, $urandom_range(2, 5));
        end
        hold(0, 6);
        apb_read(8'h0C);
        for (int i = 0; i < 3; i++) begin
            hold(1, 4);
            hold(0, 4);
        end
        hold(0, 4);
        // Clear lands on the edge that counts a new press.
        SW_RAW = 1;
        repeat (2) tick();
        apb_write(8'h0C, 32'h0);
        apb_read(8'h0C);

        // Reset while counting towards a fall.
        hold(0, 6);
        apb_write(8'h04, 32'd20);
        hold(1, 30);
        hold(0, 10);
        PRESETN = 0;
        #1;
        check("reset_mid_count_switch", {31'd0, SWITCH}, 32'd0);
        SW_RAW = 1;
        repeat (3) tick();
        PRESETN = 1;
        tick();
        read_all();
        apb_write(8'h04, 32'd2);
        apb_write(8'h00, 32'h1);
        hold(1, 12);
        check("requalify_switch", {31'd0, SWITCH}, 32'd1);
        apb_read(8'h08);
        tick();

        check("pending_switch_events", ev_cyc_q.size(), 32'd0);
        check("pending_reads", rd_q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
